// File: rtl/visited_house_counter.sv
// visited_house_counter
// Counts distinct (x, y) positions from the position tracker stream.
// A 1-bit bitmap indexed by the low coordinate bits holds the visited
// flags. After reset the bitmap is swept to zero, one address per cycle.
// Positions that arrive during that sweep wait in a small input FIFO.
// A two-stage lookup pipeline then marks new positions and counts them.
// When the upstream stream has ended and the pipeline is empty, the count
// is frozen and flagged valid.
module visited_house_counter #(
  parameter int POSITION_WIDTH = 16,
  parameter int INDEX_BITS     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pos_change,
  input  logic [POSITION_WIDTH-1:0] pos_x,
  input  logic [POSITION_WIDTH-1:0] pos_y,
  input  logic                      input_done,
  output logic                      busy,
  output logic                      overflow,
  output logic [COUNT_WIDTH-1:0]    house_count,
  output logic                      count_valid
);

  localparam int IDX_W     = 2 * INDEX_BITS;
  localparam int MAP_DEPTH = 1 << IDX_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------
  // Input index
  // ---------------------------------------------------------------------
  // Only the low INDEX_BITS of each coordinate address the bitmap, so
  // coordinates that are congruent modulo 2^INDEX_BITS share one flag.
  logic [IDX_W-1:0] in_idx;
  assign in_idx = {pos_y[INDEX_BITS-1:0], pos_x[INDEX_BITS-1:0]};

  // The upper coordinate bits are intentionally unused.
  logic unused_pos_bits;
  assign unused_pos_bits = ^{pos_x[POSITION_WIDTH-1:INDEX_BITS],
                             pos_y[POSITION_WIDTH-1:INDEX_BITS]};

  // ---------------------------------------------------------------------
  // Input FIFO (stores bitmap indices only)
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fifo_level;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             overflow_q, overflow_d;
  logic [IDX_W-1:0] head_idx;

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_level == (PTR_W+1)'(FIFO_DEPTH));
  assign head_idx   = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // Pops happen only in RUN. A pop in the same cycle frees a slot, so a
  // push into a full FIFO is still accepted when a pop happens with it.
  assign pop      = (state_q == ST_RUN) && !fifo_empty;
  assign push_req = pos_change && (state_q != ST_DONE);
  assign push     = push_req && (!fifo_full || pop);

  // FIFO pointer and sticky-overflow next state.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays have no reset. The pointers decide which entries are live, so reset values would never be read.
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= in_idx;
    end
  end

  // ---------------------------------------------------------------------
  // Clear sweep address and done latch
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] clear_addr_q, clear_addr_d;
  logic             clear_last;
  logic             done_seen_q, done_seen_d;

  assign clear_last = (clear_addr_q == {IDX_W{1'b1}});

  // Advance the sweep address in CLEAR. Latch input_done in any state.
  always_comb begin
    clear_addr_d = clear_addr_q;
    done_seen_d  = done_seen_q | input_done;
    if (state_q == ST_CLEAR) begin
      clear_addr_d = clear_addr_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Lookup pipeline: S0 = pop + read issue, S1 = read data + update
  // ---------------------------------------------------------------------
  logic             rd_data_q;
  logic             s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_fwd_q, s1_fwd_d;
  logic             s1_flag;
  logic             s1_write;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // The bitmap read returns the old contents. A lookup in S0 that hits
  // the index S1 is writing this cycle would miss that write, so the hit
  // is remembered and forced into the flag one cycle later.
  assign s1_flag  = rd_data_q | s1_fwd_q;
  assign s1_write = s1_valid_q && !s1_flag;

  // Pipeline advance and saturating count update.
  always_comb begin
    s1_valid_d = pop;
    s1_idx_d   = s1_idx_q;
    s1_fwd_d   = 1'b0;
    count_d    = count_q;
    if (pop) begin
      s1_idx_d = head_idx;
      s1_fwd_d = s1_write && (head_idx == s1_idx_q);
    end
    if (s1_write && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Visited bitmap: single write port shared by the clear sweep and S1
  // ---------------------------------------------------------------------
  logic bitmap [MAP_DEPTH];
  logic             map_we;
  logic [IDX_W-1:0] map_waddr;
  logic             map_wdata;

  // Select the bitmap writer. The sweep owns the port in CLEAR, and S1 owns it afterwards.
  always_comb begin
    map_we    = s1_write;
    map_waddr = s1_idx_q;
    map_wdata = 1'b1;
    if (state_q == ST_CLEAR) begin
      map_we    = 1'b1;
      map_waddr = clear_addr_q;
      map_wdata = 1'b0;
    end
  end

  // Bitmap write and synchronous read of the FIFO head. The read happens
  // every cycle and is only used when S1 holds a valid lookup.
  always_ff @(posedge clk) begin
    if (map_we) begin
      bitmap[map_waddr] <= map_wdata;
    end
    rd_data_q <= bitmap[head_idx];
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clear_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // An empty FIFO means nothing is in S0. Any item popped last
        // cycle is finishing S1 now and commits on this same edge, so
        // DRAIN directly follows the final S1 cycle.
        if (done_seen_q && fifo_empty) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // State and control registers, asynchronously reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= ST_CLEAR;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      clear_addr_q <= '0;
      done_seen_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_fwd_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      clear_addr_q <= clear_addr_d;
      done_seen_q  <= done_seen_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      s1_fwd_q     <= s1_fwd_d;
      count_q      <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy        = (state_q == ST_CLEAR);
  assign count_valid = (state_q == ST_DONE);
  assign overflow    = overflow_q;
  assign house_count = count_q;

endmodule

// File: tb/tb_visited_house_counter.sv
// Testbench for visited_house_counter.
// The bench uses a reduced INDEX_BITS so that each post-reset clear sweep is short.
// Each input_done pulse queues its expected final result. A monitor
// compares that result when count_valid rises.
module tb_visited_house_counter;

  localparam int PW           = 16;
  localparam int IB           = 4;
  localparam int FD           = 16;
  localparam int CW           = 16;
  localparam int CLEAR_CYCLES = 1 << (2 * IB);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pos_change = 1'b0;
  logic [PW-1:0] pos_x = '0;
  logic [PW-1:0] pos_y = '0;
  logic          input_done = 1'b0;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] house_count;
  logic          count_valid;

  visited_house_counter #(
    .POSITION_WIDTH(PW),
    .INDEX_BITS    (IB),
    .FIFO_DEPTH    (FD),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pos_change (pos_change),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .input_done (input_done),
    .busy       (busy),
    .overflow   (overflow),
    .house_count(house_count),
    .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int count;
    int ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: on each rising count_valid, pop one expected result and compare it.
  logic cv_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (count_valid && !cv_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_count_valid", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("house_count[t%0d]", mon_e.tag), house_count, mon_e.count);
        check($sformatf("overflow[t%0d]", mon_e.tag), overflow, mon_e.ovf);
      end
    end
    cv_prev <= count_valid;
  end

  // All stimulus tasks start and end on a falling clock edge.
  task automatic apply_reset();
    reset_n    = 1'b0;
    pos_change = 1'b0;
    input_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drive(input int x, input int y);
    pos_x      = PW'(x);
    pos_y      = PW'(y);
    pos_change = 1'b1;
    @(negedge clk);
    pos_change = 1'b0;
  endtask

  task automatic pulse_done(input int tag, input int count, input int ovf);
    exp_t e;
    e.tag   = tag;
    e.count = count;
    e.ovf   = ovf;
    sb_q.push_back(e);
    input_done = 1'b1;
    @(negedge clk);
    input_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < CLEAR_CYCLES + 16) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", busy, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!count_valid && n < 2 * CLEAR_CYCLES + 64) begin
      @(negedge clk);
      n++;
    end
    if (!count_valid) check("count_valid_timeout", count_valid, 1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset_n is held low from time zero.
    @(negedge clk);
    check("reset_busy", busy, 1);
    check("reset_overflow", overflow, 0);
    check("reset_house_count", house_count, 0);
    check("reset_count_valid", count_valid, 0);

    // t1: four pushes and done during CLEAR. (0,0) repeats non-consecutively.
    reset_n = 1'b1;
    drive(0, 0);
    drive(0, 1);
    drive(0, 0);
    drive(1, 1);
    check("t1_busy_during_clear", busy, 1);
    pulse_done(1, 3, 0);
    wait_valid();

    // t2: identical consecutive positions in RUN count once (forwarding).
    apply_reset();
    wait_idle();
    drive(2, 3);
    drive(2, 3);
    pulse_done(2, 1, 0);
    wait_valid();

    // t3: -1 and 255 share the same low index bits (aliasing).
    apply_reset();
    wait_idle();
    drive(-1, 0);
    drive(255, 0);
    pulse_done(3, 1, 0);
    wait_valid();

    // t4: 17 distinct pushes during CLEAR, so the 17th overflows.
    apply_reset();
    for (int i = 0; i < 16; i++) drive(i % 16, i / 16);
    check("t4_no_overflow_at_16", overflow, 0);
    drive(0, 1);
    check("t4_overflow_at_17", overflow, 1);
    pulse_done(4, 16, 1);
    wait_valid();

    // t5: the FIFO is full at the first RUN cycle. A push alongside the pop is accepted.
    apply_reset();
    for (int i = 0; i < 16; i++) drive(i, 0);
    wait_idle();
    drive(0, 2);
    check("t5_push_with_pop_no_overflow", overflow, 0);
    pulse_done(5, 17, 0);
    wait_valid();
    // Pushes in DONE are ignored and do not set overflow.
    for (int i = 0; i < 20; i++) drive(i, 3);
    check("t5_done_count_frozen", house_count, 17);
    check("t5_done_no_overflow", overflow, 0);
    check("t5_done_count_valid_held", count_valid, 1);

    // t6: done with no positions. Check when busy falls and when count_valid rises.
    apply_reset();
    pulse_done(6, 0, 0);
    repeat (CLEAR_CYCLES - 2) @(negedge clk);
    check("t6_busy_before_last_clear", busy, 1);
    @(negedge clk);
    check("t6_busy_after_clear", busy, 0);
    check("t6_cv_run_cycle", count_valid, 0);
    @(negedge clk);
    check("t6_cv_drain_cycle", count_valid, 0);
    @(negedge clk);
    check("t6_cv_done_cycle", count_valid, 1);
    @(negedge clk);

    // t7: assert reset mid-RUN, then start a fresh run.
    apply_reset();
    wait_idle();
    for (int i = 0; i < 5; i++) drive(i, 0);
    repeat (4) @(negedge clk);
    check("t7_count_before_abort", house_count, 5);
    check("t7_cv_before_abort", count_valid, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_abort_busy", busy, 1);
    check("t7_abort_overflow", overflow, 0);
    check("t7_abort_house_count", house_count, 0);
    check("t7_abort_count_valid", count_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_idle();
    drive(0, 0);
    drive(1, 0);
    pulse_done(7, 2, 0);
    wait_valid();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/visited_house_counter.md
Name: visited_house_counter

Overview:
- Sits directly downstream of the position tracker.
- Consumes its pos_change/pos_x/pos_y stream (Santa and Robo-Santa positions, plus the initial origin) and counts distinct positions visited.
- Visited flags live in a 1-bit-wide on-chip bitmap indexed by truncated coordinates. A small input FIFO absorbs positions arriving while the bitmap is being cleared after reset.
- The final count is presented once the upstream stream has ended and the pipeline has drained.

Parameters:
- POSITION_WIDTH, 16, width of pos_x/pos_y; matches the tracker.
- INDEX_BITS, 8, low bits of each coordinate used as bitmap index; bitmap holds 2^(2*INDEX_BITS) bits.
- FIFO_DEPTH, 16, input FIFO entries; power of two.
- COUNT_WIDTH, 16, width of house_count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- pos_change  in  1  valid strobe for pos_x/pos_y, one cycle per position.
- pos_x  in  POSITION_WIDTH  x coordinate, two's complement.
- pos_y  in  POSITION_WIDTH  y coordinate, two's complement.
- input_done  in  1  pulse: no further pos_change will follow.
- busy  out  1  bitmap clear in progress.
- overflow  out  1  sticky: a position arrived while the FIFO was full.
- house_count  out  COUNT_WIDTH  number of distinct positions seen.
- count_valid  out  1  house_count is final; held high until reset.

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - busy=1, overflow=0, house_count=0, count_valid=0.
  - FIFO empty, done latch cleared, state CLEAR, clear address 0.
- Bitmap index: {pos_y[INDEX_BITS-1:0], pos_x[INDEX_BITS-1:0]}. Upper coordinate bits are ignored, so coordinates congruent mod 2^INDEX_BITS alias to one index. This is accepted behaviour; input ranges are sized so it does not occur.
- FIFO behaviour:
  - Written on every pos_change in every state except DONE.
  - If the FIFO is full, the entry is dropped and overflow is set to 1 (sticky).
  - A simultaneous pop frees the slot in the same cycle, so a push with a simultaneous pop is never an overflow.
- input_done is latched (done_seen) in any state.
- State CLEAR:
  - Writes 0 to one bitmap address per cycle, ascending.
  - After writing the last address 2^(2*INDEX_BITS)-1, next state is RUN and busy drops the same edge.
  - No FIFO pops in CLEAR.
- State RUN, two-stage lookup pipeline, at most one pop per cycle:
  - S0: pop FIFO head, issue synchronous bitmap read at its index.
  - S1: read data returns. If the flag is 0: write 1 at that index and increment house_count (saturating at 2^COUNT_WIDTH-1). If the flag is 1: no action.
  - Hazard: if the S0 index equals the index being written in S1 that cycle, S0's read result is forced to 1 (forwarding). Consecutive identical positions therefore count once.
  - Throughput: one position per cycle, with no stalls.
- State DRAIN: entered from RUN when done_seen=1, the FIFO is empty and S0/S1 are empty. Lasts one cycle, then DONE.
- State DONE:
  - count_valid=1 and house_count is frozen.
  - Further pos_change is ignored, and overflow is not set by it.
- If input_done arrives during CLEAR, it is honoured after the clear and the FIFO contents are processed.
- Reset asserted mid-operation aborts everything immediately. On release, the block restarts at CLEAR and repeats the full sweep.
- Latency from the last pop to count_valid: 3 cycles (S1, DRAIN, DONE register).

Test Plan:
- After reset, push (0,0),(0,1),(0,0),(1,1) during CLEAR, then pulse input_done -> busy falls after 2^16 cycles; count_valid=1 with house_count=3; overflow=0.
- In RUN, push (2,3) on two consecutive cycles, then input_done -> house_count=1, confirming forwarding.
- In RUN, push (-1,0) then (255,0) with INDEX_BITS=8 -> house_count=1 (aliasing, documented).
- During CLEAR, push 17 positions back-to-back, all distinct -> overflow=1; house_count=16 after input_done.
- Pulse input_done with no positions -> count_valid rises 3 cycles after the clear completes, with house_count=0.
- Drop reset_n mid-RUN after 5 distinct positions -> outputs return to reset values immediately. The next run with (0,0),(1,0) gives house_count=2.
